// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encoding, timeout counter width and access-size / alignment helpers.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam int LSU_TO_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    // Access size from funct3; anything not byte or halfword is a word.
    function automatic lsu_size_t lsu_size(input logic [2:0] funct3);
        lsu_size_t sz;
        case (funct3)
            LSU_B, LSU_BU: sz = SZ_B;
            LSU_H, LSU_HU: sz = SZ_H;
            default:       sz = SZ_W;
        endcase
        return sz;
    endfunction

    // True when the low address bits are not naturally aligned for the size.
    function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic mis;
        case (lsu_size(funct3))
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the byte/halfword lane from the bus word and
// sign- or zero-extends it according to funct3. Purely combinational.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select: byte by addr[1:0], halfword by addr[1].
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension by funct3; unlisted codes pass the full word through.
    always_comb begin
        data = rdata;
        case (funct3)
            LSU_B:   data = {{24{byte_s[7]}}, byte_s};
            LSU_BU:  data = {24'h000000, byte_s};
            LSU_H:   data = {{16{half_s[15]}}, half_s};
            LSU_HU:  data = {16'h0000, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack bus transaction per instruction, store
// lane replication and byte enables, load extension, ack timeout abort.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses fault
// without a bus request instead of ignoring the offending address bits).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err,
    output logic [31:0] err_addr
);

    // Last counter value of the wait window: the counter starts at 0 on the
    // first WAIT cycle, so value ACK_TIMEOUT-1 marks the ACK_TIMEOUT-th cycle.
    localparam logic [LSU_TO_CNT_W-1:0] TO_LAST = LSU_TO_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [LSU_TO_CNT_W-1:0] CNT_MAX = {LSU_TO_CNT_W{1'b1}};

    lsu_state_t state_r, state_n_s;

    logic                    stall_r, stall_n_s;
    logic                    mem_req_r, mem_req_n_s;
    logic                    mem_we_r, mem_we_n_s;
    logic [31:0]             mem_addr_r, mem_addr_n_s;
    logic [31:0]             mem_wdata_r, mem_wdata_n_s;
    logic [3:0]              mem_be_r, mem_be_n_s;
    logic                    wb_valid_r, wb_valid_n_s;
    logic [4:0]              wb_rd_r, wb_rd_n_s;
    logic [31:0]             wb_data_r, wb_data_n_s;
    logic                    err_r, err_n_s;
    logic [31:0]             err_addr_r, err_addr_n_s;
    logic [31:0]             addr_r, addr_n_s;
    logic [2:0]              funct3_r, funct3_n_s;
    logic [4:0]              rd_r, rd_n_s;
    logic [LSU_TO_CNT_W-1:0] cnt_r, cnt_n_s;

    logic        fault_s;
    logic        timeout_s;
    logic [3:0]  st_be_s;
    logic [31:0] st_wdata_s;
    logic [31:0] ld_data_s;

`ifdef LSU_MISALIGN_TRAP_EN
    assign fault_s = lsu_misaligned(req_funct3, req_addr[1:0]);
`else
    assign fault_s = 1'b0;
`endif

    assign timeout_s = (cnt_r >= TO_LAST);

    load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_r[1:0]),
        .funct3  (funct3_r),
        .data    (ld_data_s)
    );

    // Store lane generation from the incoming request (loads read all lanes).
    always_comb begin
        st_be_s    = 4'b1111;
        st_wdata_s = 32'h0000_0000;
        if (req_we) begin
            case (lsu_size(req_funct3))
                SZ_B: begin
                    st_be_s    = 4'b0001 << req_addr[1:0];
                    st_wdata_s = {4{req_wdata[7:0]}};
                end
                SZ_H: begin
                    st_be_s    = req_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata_s = {2{req_wdata[15:0]}};
                end
                default: begin
                    st_be_s    = 4'b1111;
                    st_wdata_s = req_wdata;
                end
            endcase
        end else begin
            st_be_s    = 4'b1111;
            st_wdata_s = 32'h0000_0000;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // FSM next-state logic; ack takes priority over the timeout.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_n_s = fault_s ? RESP : WAIT;
                end else begin
                    state_n_s = IDLE;
                end
            end
            WAIT: begin
                if (mem_ack || timeout_s) begin
                    state_n_s = RESP;
                end else begin
                    state_n_s = WAIT;
                end
            end
            RESP:    state_n_s = IDLE;
            default: state_n_s = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs and captures.
    always_comb begin
        stall_n_s     = stall_r;
        mem_req_n_s   = mem_req_r;
        mem_we_n_s    = mem_we_r;
        mem_addr_n_s  = mem_addr_r;
        mem_wdata_n_s = mem_wdata_r;
        mem_be_n_s    = mem_be_r;
        wb_valid_n_s  = 1'b0;
        wb_rd_n_s     = wb_rd_r;
        wb_data_n_s   = wb_data_r;
        err_n_s       = 1'b0;
        err_addr_n_s  = err_addr_r;
        addr_n_s      = addr_r;
        funct3_n_s    = funct3_r;
        rd_n_s        = rd_r;
        cnt_n_s       = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    stall_n_s     = 1'b1;
                    addr_n_s      = req_addr;
                    funct3_n_s    = req_funct3;
                    rd_n_s        = req_rd;
                    cnt_n_s       = {LSU_TO_CNT_W{1'b0}};
                    mem_we_n_s    = req_we;
                    mem_addr_n_s  = {req_addr[31:2], 2'b00};
                    mem_be_n_s    = st_be_s;
                    mem_wdata_n_s = st_wdata_s;
                    if (fault_s) begin
                        mem_req_n_s  = 1'b0;
                        err_n_s      = 1'b1;
                        err_addr_n_s = req_addr;
                    end else begin
                        mem_req_n_s  = 1'b1;
                    end
                end else begin
                    stall_n_s   = 1'b0;
                    mem_req_n_s = 1'b0;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    mem_req_n_s = 1'b0;
                    if (!mem_we_r) begin
                        wb_valid_n_s = 1'b1;
                        wb_rd_n_s    = rd_r;
                        wb_data_n_s  = ld_data_s;
                    end else begin
                        wb_valid_n_s = 1'b0;
                    end
                end else if (timeout_s) begin
                    mem_req_n_s  = 1'b0;
                    err_n_s      = 1'b1;
                    err_addr_n_s = addr_r;
                end else begin
                    cnt_n_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 8'd1;
                end
            end
            RESP: begin
                stall_n_s   = 1'b0;
                mem_req_n_s = 1'b0;
            end
            default: begin
                stall_n_s   = 1'b0;
                mem_req_n_s = 1'b0;
            end
        endcase
    end

    // Output and capture registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r     <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            wb_valid_r  <= 1'b0;
            wb_rd_r     <= 5'd0;
            wb_data_r   <= 32'h0000_0000;
            err_r       <= 1'b0;
            err_addr_r  <= 32'h0000_0000;
            addr_r      <= 32'h0000_0000;
            funct3_r    <= 3'b000;
            rd_r        <= 5'd0;
            cnt_r       <= {LSU_TO_CNT_W{1'b0}};
        end else begin
            stall_r     <= stall_n_s;
            mem_req_r   <= mem_req_n_s;
            mem_we_r    <= mem_we_n_s;
            mem_addr_r  <= mem_addr_n_s;
            mem_wdata_r <= mem_wdata_n_s;
            mem_be_r    <= mem_be_n_s;
            wb_valid_r  <= wb_valid_n_s;
            wb_rd_r     <= wb_rd_n_s;
            wb_data_r   <= wb_data_n_s;
            err_r       <= err_n_s;
            err_addr_r  <= err_addr_n_s;
            addr_r      <= addr_n_s;
            funct3_r    <= funct3_n_s;
            rd_r        <= rd_n_s;
            cnt_r       <= cnt_n_s;
        end
    end

    assign stall     = stall_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign wb_valid  = wb_valid_r;
    assign wb_rd     = wb_rd_r;
    assign wb_data   = wb_data_r;
    assign err       = err_r;
    assign err_addr  = err_addr_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit. Two instances share the
// stimulus: dut uses the default ack timeout, dut_to uses ACK_TIMEOUT=4.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        stall, mem_req, mem_we, wb_valid, err;
    logic [31:0] mem_addr, mem_wdata, wb_data, err_addr;
    logic [3:0]  mem_be;
    logic [4:0]  wb_rd;

    logic        t_stall, t_mem_req, t_mem_we, t_wb_valid, t_err;
    logic [31:0] t_mem_addr, t_mem_wdata, t_wb_data, t_err_addr;
    logic [3:0]  t_mem_be;
    logic [4:0]  t_wb_rd;

    int n_checks;
    int n_fail;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .err(err), .err_addr(err_addr)
    );

    load_store_unit #(.ACK_TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .stall(t_stall), .mem_req(t_mem_req), .mem_we(t_mem_we),
        .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_be(t_mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(t_wb_valid),
        .wb_rd(t_wb_rd), .wb_data(t_wb_data), .err(t_err), .err_addr(t_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle (cycle N) and advance to cycle N+1.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        tick();
        req_valid  = 1'b0;
    endtask

    // Load acknowledged on its first WAIT cycle.
    task automatic load_one(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [4:0] rd, input logic [31:0] rdata,
                            input logic [31:0] exp_data);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        issue(1'b0, f3, addr, 32'h0000_0000, rd);
        check_eq({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
        check_eq({tag, " mem_addr"}, mem_addr, exp_addr);
        check_eq({tag, " mem_be"}, {28'd0, mem_be}, 32'h0000_000F);
        check_eq({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        check_eq({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
        check_eq({tag, " wb_data"}, wb_data, exp_data);
        check_eq({tag, " wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
        check_eq({tag, " mem_req off"}, {31'd0, mem_req}, 32'd0);
        tick();
        check_eq({tag, " wb_valid end"}, {31'd0, wb_valid}, 32'd0);
        check_eq({tag, " stall end"}, {31'd0, stall}, 32'd0);
    endtask

    // Store acknowledged on its first WAIT cycle.
    task automatic store_one(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata);
        issue(1'b1, f3, addr, wdata, 5'd0);
        check_eq({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
        check_eq({tag, " mem_we"}, {31'd0, mem_we}, 32'd1);
        check_eq({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        check_eq({tag, " mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
        check_eq({tag, " mem_wdata"}, mem_wdata, exp_wdata);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq({tag, " no wb_valid"}, {31'd0, wb_valid}, 32'd0);
        check_eq({tag, " stall resp"}, {31'd0, stall}, 32'd1);
        tick();
        check_eq({tag, " stall end"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0000;
        req_wdata  = 32'h0000_0000;
        req_rd     = 5'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst stall", {31'd0, stall}, 32'd0);
        check_eq("rst mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst mem_addr", mem_addr, 32'd0);
        check_eq("rst wb_data", wb_data, 32'd0);
        check_eq("rst err_addr", err_addr, 32'd0);
        check_eq("rst wb_valid", {31'd0, wb_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        load_one("LB",  3'b000, 32'h0000_1003, 5'd5, 32'h80FF_1234, 32'hFFFF_FF80);
        load_one("LBU", 3'b100, 32'h0000_1003, 5'd6, 32'h80FF_1234, 32'h0000_0080);
        load_one("LH",  3'b001, 32'h0000_1002, 5'd2, 32'h80FF_1234, 32'hFFFF_80FF);
        load_one("LHU", 3'b101, 32'h0000_1000, 5'd0, 32'h80FF_9234, 32'h0000_9234);
        store_one("SH", 3'b001, 32'h0000_2002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
        store_one("SB", 3'b000, 32'h0000_2001, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
        store_one("SW", 3'b010, 32'h0000_2004, 32'h0BAD_CAFE, 4'b1111, 32'h0BAD_CAFE);

        // LW with ack on the sixth WAIT cycle.
        issue(1'b0, 3'b010, 32'h0000_3000, 32'h0000_0000, 5'd3);
        for (int i = 0; i < 6; i++) begin
            check_eq("LWdly mem_req", {31'd0, mem_req}, 32'd1);
            check_eq("LWdly stall", {31'd0, stall}, 32'd1);
            check_eq("LWdly mem_addr", mem_addr, 32'h0000_3000);
            if (i == 5) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        mem_ack = 1'b0;
        check_eq("LWdly wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("LWdly wb_data", wb_data, 32'hDEAD_BEEF);
        tick();
        check_eq("LWdly stall end", {31'd0, stall}, 32'd0);

        // Timeout on the 4-cycle instance, then a late ack it must ignore.
        issue(1'b0, 3'b010, 32'h0000_3000, 32'h0000_0000, 5'd7);
        for (int i = 0; i < 4; i++) begin
            check_eq("TO mem_req", {31'd0, t_mem_req}, 32'd1);
            check_eq("TO err early", {31'd0, t_err}, 32'd0);
            tick();
        end
        check_eq("TO err", {31'd0, t_err}, 32'd1);
        check_eq("TO err_addr", t_err_addr, 32'h0000_3000);
        check_eq("TO mem_req off", {31'd0, t_mem_req}, 32'd0);
        check_eq("TO no wb_valid", {31'd0, t_wb_valid}, 32'd0);
        check_eq("TO stall resp", {31'd0, t_stall}, 32'd1);
        tick();
        check_eq("TO err end", {31'd0, t_err}, 32'd0);
        check_eq("TO stall end", {31'd0, t_stall}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack   = 1'b0;
        check_eq("TO late ack wb_valid", {31'd0, t_wb_valid}, 32'd0);
        check_eq("TO late ack err", {31'd0, t_err}, 32'd0);
        check_eq("TO late ack mem_req", {31'd0, t_mem_req}, 32'd0);
        check_eq("long dut wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("long dut wb_data", wb_data, 32'h1234_5678);
        tick();
        check_eq("long dut stall end", {31'd0, stall}, 32'd0);

        // Ack on the very cycle the timeout would fire: ack wins.
        issue(1'b0, 3'b010, 32'h0000_3004, 32'h0000_0000, 5'd8);
        repeat (3) tick();
        check_eq("AW mem_req", {31'd0, t_mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack   = 1'b0;
        check_eq("AW wb_valid", {31'd0, t_wb_valid}, 32'd1);
        check_eq("AW no err", {31'd0, t_err}, 32'd0);
        check_eq("AW wb_data", t_wb_data, 32'h0BAD_F00D);
        tick();

        // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h0000_4001, 32'h0000_0000, 5'd9);
        check_eq("MIS mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("MIS err", {31'd0, err}, 32'd1);
        check_eq("MIS err_addr", err_addr, 32'h0000_4001);
        check_eq("MIS stall", {31'd0, stall}, 32'd1);
        check_eq("MIS wb_valid", {31'd0, wb_valid}, 32'd0);
        tick();
        check_eq("MIS err end", {31'd0, err}, 32'd0);
        check_eq("MIS stall end", {31'd0, stall}, 32'd0);
`else
        load_one("MIS", 3'b010, 32'h0000_4001, 5'd9, 32'hCAFE_F00D, 32'hCAFE_F00D);
        check_eq("MIS no err", {31'd0, err}, 32'd0);
`endif

        // Asynchronous reset in the middle of WAIT.
        issue(1'b0, 3'b010, 32'h0000_5000, 32'h0000_0000, 5'd4);
        check_eq("RST pre mem_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("RST mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("RST stall", {31'd0, stall}, 32'd0);
        check_eq("RST mem_addr", mem_addr, 32'd0);
        check_eq("RST mem_be", {28'd0, mem_be}, 32'd0);
        check_eq("RST wb_data", wb_data, 32'd0);
        check_eq("RST err_addr", err_addr, 32'd0);
        check_eq("RST to mem_req", {31'd0, t_mem_req}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("SPUR wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("SPUR err", {31'd0, err}, 32'd0);
        check_eq("SPUR stall", {31'd0, stall}, 32'd0);
        check_eq("SPUR mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        check_eq("SPUR wb_valid 2", {31'd0, wb_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
